// File: rtl/decade_scan_ctrl.sv
// BCD scan sequencer feeding a 4-to-10 one-hot decoder: steps code 0..LAST at a programmable rate.
// Optional: define DECADE_SCAN_BOUNCE_EN to make the code reverse direction at the ends instead of wrapping.
module decade_scan_ctrl #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned LAST  = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [3:0]       load_val,
    output logic [3:0]       code,
    output logic             step,
    output logic             wrap,
    output logic             done,
    output logic             busy
);

    localparam logic [3:0] LAST_C = 4'(LAST);
    localparam int unsigned PASS_W = 5;
`ifdef DECADE_SCAN_BOUNCE_EN
    localparam int unsigned PASS_LEN = 2 * LAST;
`else
    localparam int unsigned PASS_LEN = LAST + 1;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    pre, pre_nxt;
    logic [DIV_W-1:0]    div_q, div_nxt;
    logic [PASS_W-1:0]   pass, pass_nxt;
    logic                cont_q, cont_nxt;
    logic                dir_q, dir_nxt;
    logic [3:0]          code_nxt, code_adv;
    logic                wrap_adv;
    logic                step_nxt, wrap_nxt, done_nxt, busy_nxt;
`ifdef DECADE_SCAN_BOUNCE_EN
    logic                going_down;
    logic                dir_adv;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            code   <= 4'd0;
            pre    <= '0;
            pass   <= '0;
            div_q  <= '0;
            cont_q <= 1'b0;
            dir_q  <= 1'b0;
            step   <= 1'b0;
            wrap   <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            code   <= code_nxt;
            pre    <= pre_nxt;
            pass   <= pass_nxt;
            div_q  <= div_nxt;
            cont_q <= cont_nxt;
            dir_q  <= dir_nxt;
            step   <= step_nxt;
            wrap   <= wrap_nxt;
            done   <= done_nxt;
            busy   <= busy_nxt;
        end
    end

    // Next state, next code and next output pulses
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        pre_nxt   = pre;
        pass_nxt  = pass;
        div_nxt   = div_q;
        cont_nxt  = cont_q;
        dir_nxt   = dir_q;
        step_nxt  = 1'b0;
        wrap_nxt  = 1'b0;

`ifdef DECADE_SCAN_BOUNCE_EN
        // An end reached in the travel direction turns around before stepping
        going_down = dir_q;
        if (!dir_q && code == LAST_C)
            going_down = 1'b1;
        else if (dir_q && code == 4'd0)
            going_down = 1'b0;
        code_adv = going_down ? code - 4'd1 : code + 4'd1;
        wrap_adv = going_down ? (code_adv == 4'd0) : (code_adv == LAST_C);
        dir_adv  = going_down ^ wrap_adv;
`else
        if (dir_q) begin
            code_adv = (code == 4'd0) ? LAST_C : code - 4'd1;
            wrap_adv = (code == 4'd0);
        end else begin
            code_adv = (code == LAST_C) ? 4'd0 : code + 4'd1;
            wrap_adv = (code == LAST_C);
        end
`endif

        case (state)
            IDLE: begin
                if (start && !stop && !load) begin
                    state_nxt = SCAN;
                    div_nxt   = div;
                    cont_nxt  = cont;
                    dir_nxt   = dir;
                    pre_nxt   = '0;
                    pass_nxt  = '0;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (!load) begin
                    if (pre == div_q) begin
                        pre_nxt  = '0;
                        code_nxt = code_adv;
                        step_nxt = 1'b1;
                        wrap_nxt = wrap_adv;
`ifdef DECADE_SCAN_BOUNCE_EN
                        dir_nxt  = dir_adv;
`endif
                        if (!cont_q) begin
                            pass_nxt = pass + PASS_W'(1);
                            if (pass == PASS_W'(PASS_LEN - 1))
                                state_nxt = DONE;
                        end
                    end else begin
                        pre_nxt = pre + DIV_W'(1);
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Preload overrides stepping and the stop hold, but not stop's return to IDLE
        if (load) begin
            code_nxt = (load_val > LAST_C) ? 4'd0 : load_val;
            pre_nxt  = '0;
            pass_nxt = '0;
        end

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

endmodule
